// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and helpers for the binary-to-7-segment feeder.
package seg7_pkg;

   localparam int unsigned BCD_DIGITS = 4;
   localparam int unsigned BIN_W      = 14;
   localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned SEG_W      = 8;
   localparam int unsigned MAX_VALUE  = 9999;

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(BIN_W - 1);

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   // Segment pattern (g..a) for one BCD digit; non-decimal codes show nothing.
   function automatic logic [6:0] digit_pattern(input logic [3:0] nibble);
      logic [6:0] pat;
      case (nibble)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      return adj;
   endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// One digit of segment encoding: dash overrides blank, which overrides the digit.
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [3:0]       nibble,
   input  logic             blank,
   input  logic             dash,
   input  logic             dp,
   output logic [SEG_W-1:0] pattern
);

   logic [6:0] segs;

   always_comb begin
      segs = SEG_BLANK;
      if (dash)        segs = SEG_DASH;
      else if (!blank) segs = digit_pattern(nibble);
   end

   assign pattern = {dp, segs};

endmodule

// File: rtl/seg4_bin_encoder.sv
// Binary to four-digit 7-segment feeder: sequential double-dabble, then an
// atomic update of all four digit registers when the conversion completes.
module seg4_bin_encoder
   import seg7_pkg::*;
#(
   parameter bit BLANK_LZ       = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIN_W-1:0] in_value,
   input  logic [3:0]       in_dp,
   output logic [SEG_W-1:0] seg_a,
   output logic [SEG_W-1:0] seg_b,
   output logic [SEG_W-1:0] seg_c,
   output logic [SEG_W-1:0] seg_d,
   output logic             done,
   output logic             ovf
);

   localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};

   state_t                                state_q, state_nxt;
   logic [BIN_W-1:0]                      shift_q, shift_nxt;
   logic [BCD_W-1:0]                      bcd_q, bcd_nxt;
   logic [CNT_W-1:0]                      cnt_q, cnt_nxt;
   logic [BCD_DIGITS-1:0]                 dp_q, dp_nxt;
   logic                                  ovf_pend_q, ovf_pend_nxt;
   logic [BCD_DIGITS-1:0][SEG_W-1:0]      seg_q, seg_nxt;
   logic                                  done_q, done_nxt;
   logic                                  ovf_q, ovf_nxt;

   logic [BCD_DIGITS-1:0]                 blank;
   logic [BCD_DIGITS-1:0][SEG_W-1:0]      dec;

   // Leading-zero blanking chain from the thousands digit down; ones never blanks.
   always_comb begin
      blank = '0;
      blank[BCD_DIGITS-1] = BLANK_LZ && (bcd_q[BCD_W-1 -: 4] == 4'd0);
      for (int k = int'(BCD_DIGITS) - 2; k >= 1; k--) begin
         blank[k] = blank[k+1] && (bcd_q[4*k +: 4] == 4'd0);
      end
   end

   for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_dig
      seg7_digit_decode u_dec (
         .nibble  (bcd_q[4*k +: 4]),
         .blank   (blank[k]),
         .dash    (ovf_pend_q),
         .dp      (dp_q[k]),
         .pattern (dec[k])
      );
   end

   // Next-state and datapath
   always_comb begin
      state_nxt    = state_q;
      shift_nxt    = shift_q;
      bcd_nxt      = bcd_q;
      cnt_nxt      = cnt_q;
      dp_nxt       = dp_q;
      ovf_pend_nxt = ovf_pend_q;
      seg_nxt      = seg_q;
      done_nxt     = 1'b0;
      ovf_nxt      = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_nxt    = ST_SHIFT;
               shift_nxt    = in_value;
               dp_nxt       = in_dp;
               ovf_pend_nxt = (in_value > BIN_W'(MAX_VALUE));
               bcd_nxt      = '0;
               cnt_nxt      = SHIFT_LAST;
            end
         end
         ST_SHIFT: begin
            {bcd_nxt, shift_nxt} = {dabble_adjust(bcd_q), shift_q} << 1;
            cnt_nxt = cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            for (int k = 0; k < int'(BCD_DIGITS); k++) seg_nxt[k] = dec[k] ^ SEG_OFF;
            ovf_nxt   = ovf_pend_q;
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         dp_q       <= '0;
         ovf_pend_q <= 1'b0;
         seg_q      <= {BCD_DIGITS{SEG_OFF}};
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         shift_q    <= shift_nxt;
         bcd_q      <= bcd_nxt;
         cnt_q      <= cnt_nxt;
         dp_q       <= dp_nxt;
         ovf_pend_q <= ovf_pend_nxt;
         seg_q      <= seg_nxt;
         done_q     <= done_nxt;
         ovf_q      <= ovf_nxt;
      end
   end

   assign in_ready = (state_q == ST_IDLE);
   assign seg_a    = seg_q[0];
   assign seg_b    = seg_q[1];
   assign seg_c    = seg_q[2];
   assign seg_d    = seg_q[3];
   assign done     = done_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_seg4_bin_encoder.sv
// Bench for seg4_bin_encoder: vector table plus handshake and reset corner cases,
// checked through an expected-result queue against active-high and active-low copies.
module tb_seg4_bin_encoder;

   typedef struct packed {
      logic [31:0] segs;   // {seg_d, seg_c, seg_b, seg_a}, active-high
      logic        ovf;
   } exp_t;

   typedef struct {
      int unsigned value;
      logic [3:0]  dp;
      logic [31:0] segs;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [13:0] in_value = '0;
   logic [3:0]  in_dp = '0;

   logic       in_ready, done, ovf;
   logic [7:0] seg_a, seg_b, seg_c, seg_d;
   logic       in_ready_l, done_l, ovf_l;
   logic [7:0] seg_a_l, seg_b_l, seg_c_l, seg_d_l;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   acc_cyc = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   seg4_bin_encoder #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .in_dp(in_dp),
      .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
      .done(done), .ovf(ovf)
   );

   seg4_bin_encoder #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
      .in_value(in_value), .in_dp(in_dp),
      .seg_a(seg_a_l), .seg_b(seg_b_l), .seg_c(seg_c_l), .seg_d(seg_d_l),
      .done(done_l), .ovf(ovf_l)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
      endcase
   endfunction

   // Decimal-arithmetic reference for arbitrary values
   function automatic exp_t model(input int unsigned v, input logic [3:0] dp);
      exp_t       e;
      logic [6:0] s [4];
      int         dig [4];
      bit         lead;
      lead   = 1'b1;
      dig[0] = int'(v % 10);
      dig[1] = int'((v / 10) % 10);
      dig[2] = int'((v / 100) % 10);
      dig[3] = int'((v / 1000) % 10);
      for (int k = 3; k >= 0; k--) begin
         if (v > 9999)                        s[k] = 7'h40;
         else if (lead && dig[k] == 0 && k != 0) s[k] = 7'h00;
         else begin
            s[k] = pat(dig[k]);
            lead = 1'b0;
         end
      end
      e.segs = {dp[3], s[3], dp[2], s[2], dp[1], s[1], dp[0], s[0]};
      e.ovf  = (v > 9999);
      return e;
   endfunction

   task automatic send(input int unsigned v, input logic [3:0] dp, input exp_t e);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (in_ready !== 1'b1) begin
         n_cmp++; n_fail++;
         $display("FAIL send_ready_timeout: in_ready=%b, expected 1", in_ready);
         return;
      end
      in_valid = 1'b1;
      in_value = 14'(v);
      in_dp    = dp;
      @(posedge clk); #1;
      acc_cyc = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string name);
      int   n;
      exp_t e;
      n = 0;
      while (done !== 1'b1 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      if (done !== 1'b1) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_done_timeout: done=%b, expected 1", name, done);
         return;
      end
      check({name, "_latency"}, 32'(cyc - acc_cyc), 32'd15);
      check({name, "_ready_at_done"}, 32'(in_ready), 32'd1);
      check({name, "_done_l"}, 32'(done_l), 32'd1);
      if (sb.size() == 0) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_unexpected_done: queue size 0, expected 1", name);
      end else begin
         e = sb.pop_front();
         check({name, "_segs"}, {seg_d, seg_c, seg_b, seg_a}, e.segs);
         check({name, "_ovf"}, 32'(ovf), 32'(e.ovf));
         check({name, "_segs_l"}, {seg_d_l, seg_c_l, seg_b_l, seg_a_l}, ~e.segs);
         check({name, "_ovf_l"}, 32'(ovf_l), 32'(e.ovf));
      end
      @(posedge clk); #1;
      check({name, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   vec_t vecs [13];

   initial begin
      int dc0;
      int unsigned rv;
      logic [3:0]  rdp;

      vecs[0]  = '{1234,  4'b0100, 32'h06DB4F66, 1'b0};
      vecs[1]  = '{7,     4'b0000, 32'h00000007, 1'b0};
      vecs[2]  = '{0,     4'b0000, 32'h0000003F, 1'b0};
      vecs[3]  = '{9999,  4'b0000, 32'h6F6F6F6F, 1'b0};
      vecs[4]  = '{10000, 4'b0000, 32'h40404040, 1'b1};
      vecs[5]  = '{42,    4'b0000, 32'h0000665B, 1'b0};
      vecs[6]  = '{16383, 4'b1111, 32'hC0C0C0C0, 1'b1};
      vecs[7]  = '{10,    4'b0001, 32'h000006BF, 1'b0};
      vecs[8]  = '{1000,  4'b1000, 32'h863F3F3F, 1'b0};
      vecs[9]  = '{5,     4'b0110, 32'h0080806D, 1'b0};
      vecs[10] = '{8,     4'b0000, 32'h0000007F, 1'b0};
      vecs[11] = '{3006,  4'b0000, 32'h4F3F3F7D, 1'b0};
      vecs[12] = '{9000,  4'b0011, 32'h6F3FBFBF, 1'b0};

      // Reset state on both polarities
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_segs", {seg_d, seg_c, seg_b, seg_a}, 32'h00000000);
      check("rst_segs_l", {seg_d_l, seg_c_l, seg_b_l, seg_a_l}, 32'hFFFFFFFF);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_ready_l", 32'(in_ready_l), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         send(vecs[i].value, vecs[i].dp, '{vecs[i].segs, vecs[i].ovf});
         wait_result($sformatf("vec%0d_%0d", i, vecs[i].value));
      end

      for (int i = 0; i < 6; i++) begin
         rv  = $urandom_range(0, 16383);
         rdp = 4'($urandom_range(0, 15));
         send(rv, rdp, model(rv, rdp));
         wait_result($sformatf("rnd%0d_%0d", i, rv));
      end

      // in_valid held across a busy window: 100 then 200, with a glitch on in_value
      dc0 = done_cnt;
      in_valid = 1'b1;
      in_value = 14'd100;
      in_dp    = 4'b0000;
      @(posedge clk); #1;
      acc_cyc = cyc;
      sb.push_back(model(100, 4'b0000));
      in_value = 14'd200;
      repeat (4) begin @(posedge clk); #1; end
      in_value = 14'd999;
      @(posedge clk); #1;
      in_value = 14'd200;
      wait_result("busy100");
      check("busy_accept_e16", 32'(in_ready), 32'd0);
      acc_cyc = cyc;
      sb.push_back(model(200, 4'b0000));
      in_valid = 1'b0;
      wait_result("busy200");
      check("busy_done_count", 32'(done_cnt - dc0), 32'd2);

      // Leave ovf set, then reset in the middle of converting 5555
      send(10000, 4'b0000, model(10000, 4'b0000));
      wait_result("pre_rst_ovf");
      dc0 = done_cnt;
      send(5555, 4'b1010, model(5555, 4'b1010));
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      check("midrst_segs", {seg_d, seg_c, seg_b, seg_a}, 32'h00000000);
      check("midrst_segs_l", {seg_d_l, seg_c_l, seg_b_l, seg_a_l}, 32'hFFFFFFFF);
      check("midrst_ovf", 32'(ovf), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd1);
      repeat (20) @(posedge clk);
      #1;
      check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
      check("midrst_hold_segs", {seg_d, seg_c, seg_b, seg_a}, 32'h00000000);

      // Recovery after reset
      send(42, 4'b0000, model(42, 4'b0000));
      wait_result("post_rst_42");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
